coupler: RTL and testbench
==========================

COUPLER -- requirements
Module: coupler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input word width; the output word is 2*DATA_WIDTH.
REQ-002 SHALL have parameter DEPTH, default 8, number of output FIFO entries; power of two, at least 2.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port i_data, input, DATA_WIDTH bits: input word.
REQ-007 SHALL have port i_enq, input, 1 bit: write request for i_data.
REQ-008 SHALL have port i_deq, input, 1 bit: pop request for the head output word.
REQ-009 SHALL have port o_data, output, 2*DATA_WIDTH bits: head output word (show-ahead).
REQ-010 SHALL have port o_empty, output, 1 bit: no complete output word available.
REQ-011 SHALL have port o_full, output, 1 bit: input word cannot be accepted this cycle.

Function
REQ-012 SHALL pair consecutive accepted input words: the first word goes to o_data[2*DATA_WIDTH-1:DATA_WIDTH] and the second to o_data[DATA_WIDTH-1:0].
REQ-013 SHALL hold an unpaired word in a half register (half_valid flag) until its partner arrives.
REQ-014 SHALL write the completed pair into the output FIFO on the edge that accepts the second word; the pair becomes visible (o_empty=0) on the next cycle.
REQ-015 SHALL accept a word when i_enq=1 and o_full=0; SHALL ignore i_enq while o_full=1, with no state change.
REQ-016 SHALL drive o_full = half_valid AND (FIFO count == DEPTH), combinationally from registered state; a same-cycle pop SHALL NOT clear o_full.
REQ-017 SHALL drive o_empty = (FIFO count == 0); a half-filled word SHALL NOT deassert o_empty.
REQ-018 SHALL present o_data as the FIFO head combinationally, valid whenever o_empty=0; SHALL drive 0 when o_empty=1.
REQ-019 SHALL pop the head on an edge where i_deq=1 and o_empty=0; SHALL ignore i_deq while o_empty=1.
REQ-020 SHALL perform a push and a pop on the same edge when both are legal; the count is then unchanged.
REQ-021 SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-022 SHALL preserve strict FIFO order of pairs, with no loss or duplication.

Reset
REQ-023 SHALL, while i_rst_n=0 at an edge, clear count, pointers and half_valid; i_enq and i_deq are ignored in that cycle.
REQ-024 SHALL hold these outputs after reset: o_empty=1, o_full=0, o_data=0.
REQ-025 SHALL discard all stored words, including a pending half word, on a reset asserted mid-operation.
REQ-026 SHALL NOT require a reset for FIFO storage contents.

Configuration
REQ-027 SHALL, when macro COUPLER_ERR_CHECK_EN is defined, add output port o_err (1 bit).
REQ-028 SHALL set o_err sticky on any edge with i_enq=1 and o_full=1, or with i_deq=1 and o_empty=1.
REQ-029 SHALL clear o_err only by reset.
REQ-030 SHALL, when COUPLER_ERR_CHECK_EN is undefined, omit the o_err port and its logic; illegal requests are silently ignored.

Verification
REQ-031 SHALL cover pairing: after reset, enqueue 0x00000001 then 0x00000002, no deq -> o_empty=0 one cycle after the second enqueue, o_data=0x0000000100000002.
REQ-032 SHALL cover streaming: enqueue 0..127 continuously with i_enq=~o_full and i_deq=~o_empty -> 64 outputs in order, output k = {2k, 2k+1}.
REQ-033 SHALL cover full: enqueue 17 words with DEPTH=8 and no deq -> o_full=1; an 18th enqueue is ignored; one deq then clears o_full on the next cycle.
REQ-034 SHALL cover empty: i_deq=1 while empty -> no state change and o_data=0; with COUPLER_ERR_CHECK_EN defined, o_err=1.
REQ-035 SHALL cover simultaneous operation: push and pop on the same edge with count 3 -> count stays 3.
REQ-036 SHALL cover wrap-around: 40 pairs through DEPTH=8 -> data stays correct and in order.
REQ-037 SHALL cover reset mid-operation: reset with half_valid=1 and count=5 -> o_empty=1 and o_full=0 next cycle; the next two words form the first output.

Source files
------------

// File: rtl/coupler.sv
// coupler: pairs consecutive input words into double-width words queued in a show-ahead FIFO.
// Defining COUPLER_ERR_CHECK_EN adds a sticky o_err flag for illegal enq/deq requests.
module coupler #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_enq,
    input  logic                    i_deq,
    output logic [2*DATA_WIDTH-1:0] o_data,
    output logic                    o_empty,
    output logic                    o_full
`ifdef COUPLER_ERR_CHECK_EN
    ,
    output logic                    o_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0]   half_q;
    logic                    half_valid;
    logic [2*DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    accept, push, pop;
    always_comb begin
        o_full  = half_valid && (count == (AW+1)'(DEPTH));
        o_empty = (count == '0);
        o_data  = o_empty ? '0 : mem[rd_ptr];
        accept  = i_enq && !o_full;
        push    = accept && half_valid;
        pop     = i_deq && !o_empty;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            half_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (accept) half_valid <= !half_valid;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Storage needs no reset: half_valid and count qualify every read.
    always_ff @(posedge i_clk) begin
        if (accept && !half_valid) half_q <= i_data;
        if (push) mem[wr_ptr] <= {half_q, i_data};
    end
`ifdef COUPLER_ERR_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) o_err <= 1'b0;
        else if ((i_enq && o_full) || (i_deq && o_empty)) o_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_coupler.sv
// tb_coupler: scoreboard bench for coupler; pairs expected at push, compared at pop.
module tb_coupler;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    logic          i_clk, i_rst_n, i_enq, i_deq;
    logic [DW-1:0] i_data;
    logic [2*DW-1:0] o_data;
    logic          o_empty, o_full;
    int            n_cmp = 0, n_bad = 0;
    logic [2*DW-1:0] sb[$];
    logic          m_hv;
    logic [DW-1:0] m_half;
`ifdef COUPLER_ERR_CHECK_EN
    logic          o_err, m_err;
`endif

    coupler #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_enq(i_enq), .i_deq(i_deq),
        .o_data(o_data), .o_empty(o_empty), .o_full(o_full)
`ifdef COUPLER_ERR_CHECK_EN
        , .o_err(o_err)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_full();
        return m_hv && (sb.size() == DEPTH);
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0; i_enq = 1'b1; i_deq = 1'b1; i_data = 32'hdead_beef;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1; i_enq = 1'b0; i_deq = 1'b0;
        sb.delete(); m_hv = 1'b0;
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_data", o_data, 0);
`ifdef COUPLER_ERR_CHECK_EN
        m_err = 1'b0;
        chk("rst_err", o_err, 0);
`endif
    endtask

    task automatic cycle(input logic enq, input logic [DW-1:0] d, input logic deq);
        logic mf, me;
        i_enq = enq; i_data = d; i_deq = deq;
        mf = m_full();
        me = (sb.size() == 0);
        chk("empty", o_empty, me);
        chk("full", o_full, mf);
        chk("count", 64'(dut.count), 64'(sb.size()));
        if (me) chk("data_idle", o_data, 0);
        else if (deq) chk("data_pop", o_data, sb.pop_front());
`ifdef COUPLER_ERR_CHECK_EN
        chk("err", o_err, m_err);
        if ((enq && mf) || (deq && me)) m_err = 1'b1;
`endif
        @(posedge i_clk);
        if (enq && !mf) begin
            if (m_hv) sb.push_back({m_half, d});
            else m_half = d;
            m_hv = !m_hv;
        end
        #1;
        i_enq = 1'b0; i_deq = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 4 * DEPTH && sb.size() != 0; g++) cycle(1'b0, '0, 1'b1);
        chk("drained", 64'(sb.size()), 0);
    endtask

    initial begin
        int k, g;
        i_rst_n = 1'b0; i_enq = 1'b0; i_deq = 1'b0; i_data = '0; m_hv = 1'b0; m_half = '0;
        do_reset();
        // pairing
        cycle(1'b1, 32'h1, 1'b0);
        cycle(1'b1, 32'h2, 1'b0);
        chk("pair_empty", o_empty, 0);
        chk("pair_data", o_data, 64'h0000_0001_0000_0002);
        drain();
        // streaming with flow control from the model
        do_reset();
        k = 0;
        for (g = 0; g < 1000 && k < 128; g++) begin
            logic e;
            e = !m_full();
            cycle(e, DW'(k), sb.size() != 0);
            if (e) k++;
        end
        chk("stream_done", 64'(k), 128);
        drain();
        // full
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0);
        chk("full17", o_full, 1);
        cycle(1'b1, 32'hbad0, 1'b0);
        chk("full18_count", 64'(dut.count), DEPTH);
        cycle(1'b0, '0, 1'b1);
        chk("full_cleared", o_full, 0);
        cycle(1'b1, 32'h200, 1'b0);
        drain();
        // deq while empty
        do_reset();
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("empty_data", o_data, 0);
        chk("empty_count", 64'(dut.count), 0);
`ifdef COUPLER_ERR_CHECK_EN
        chk("empty_err", o_err, 1);
`endif
        // simultaneous push and pop at count 3
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'(32'h300 + i), 1'b0);
        cycle(1'b1, 32'h307, 1'b1);
        chk("simul_count", 64'(dut.count), 3);
        drain();
        // wrap-around: 40 pairs with random pops
        do_reset();
        k = 0;
        for (g = 0; g < 2000 && k < 80; g++) begin
            logic e;
            e = !m_full() && ($urandom_range(0, 3) != 0);
            cycle(e, $urandom, (sb.size() != 0) && ($urandom_range(0, 2) != 0));
            if (e) k++;
        end
        chk("wrap_done", 64'(k), 80);
        drain();
        // reset mid-operation with a pending half word
        do_reset();
        for (int i = 0; i < 11; i++) cycle(1'b1, DW'(32'h400 + i), 1'b0);
        chk("mid_count", 64'(dut.count), 5);
        do_reset();
        cycle(1'b1, 32'haaaa_0001, 1'b0);
        cycle(1'b1, 32'hbbbb_0002, 1'b0);
        chk("mid_first", o_data, 64'haaaa_0001_bbbb_0002);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
